// File: rtl/note_sequencer.sv
// Multi-voice step sequencer: plays (pitch, length) steps from a pattern RAM at a programmable tempo.
// Optional SEQ_TRANSPOSE_EN adds a global signed transpose input applied to every voice.
module note_sequencer #(
  parameter int N_VOICES = 2,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NOTE_W   = 6,
  parameter int NOTE_MAX = 40,
  parameter int LEN_W    = 4,
  parameter int TICK_W   = 16,
  parameter int OFF_W    = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_tick,
  input  logic                         start,
  input  logic                         stop,
  input  logic [TICK_W-1:0]            tempo_div,
  input  logic [ADDR_W:0]              loop_len,
  input  logic [N_VOICES*OFF_W-1:0]    voice_offset,
`ifdef SEQ_TRANSPOSE_EN
  input  logic [OFF_W-1:0]             transpose,
`endif
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [NOTE_W-1:0]            wr_pitch,
  input  logic [LEN_W-1:0]             wr_len,
  output logic [N_VOICES*NOTE_W-1:0]   voice_note,
  output logic [N_VOICES-1:0]          gate,
  output logic [N_VOICES-1:0]          env_reset,
  output logic [ADDR_W-1:0]            step_idx,
  output logic                         playing,
  output logic                         loop_wrap
);

  localparam int WORD_W = NOTE_W + LEN_W;
  localparam int SUM_W  = NOTE_W + 2;
  localparam logic [NOTE_W-1:0] REST_CODE = '1;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  state_t              state;
  logic                fetch_phase;
  logic [TICK_W-1:0]   tick_cnt;
  logic [LEN_W-1:0]    unit_cnt;
  logic [LEN_W-1:0]    len_cur;

  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   rd_data;

  // Pattern RAM: one write port, registered read of the current step.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_pitch, wr_len};
    end
    rd_data <= mem[step_idx];
  end

  logic [NOTE_W-1:0] rd_pitch;
  logic [LEN_W-1:0]  rd_len;
  logic              is_rest;
  assign rd_pitch = rd_data[WORD_W-1:LEN_W];
  assign rd_len   = rd_data[LEN_W-1:0];
  assign is_rest  = (rd_pitch == REST_CODE);

  logic [TICK_W-1:0] tdiv_last;
  logic [ADDR_W:0]   loop_eff;
  logic [ADDR_W:0]   loop_last;
  logic              unit_end;
  logic              step_end;

  assign tdiv_last = (tempo_div == '0) ? '0 : tempo_div - 1'b1;
  assign loop_eff  = ((loop_len == '0) || (loop_len > (ADDR_W+1)'(DEPTH))) ? (ADDR_W+1)'(DEPTH) : loop_len;
  assign loop_last = loop_eff - 1'b1;
  // >= keeps a lowered tempo_div from letting tick_cnt run past the boundary.
  assign unit_end  = (tick_cnt >= tdiv_last);
  assign step_end  = unit_end && (unit_cnt == len_cur - 1'b1);

  logic [SUM_W-1:0] trans_ext;
`ifdef SEQ_TRANSPOSE_EN
  assign trans_ext = {{(SUM_W-OFF_W){transpose[OFF_W-1]}}, transpose};
`else
  assign trans_ext = '0;
`endif

  logic [N_VOICES-1:0]        hit;
  logic [N_VOICES*NOTE_W-1:0] note_upd;

  generate
    for (genvar gi = 0; gi < N_VOICES; gi++) begin : gen_voice
      logic [OFF_W-1:0] off;
      logic [SUM_W-1:0] sum;
      logic             in_range;
      assign off      = voice_offset[gi*OFF_W +: OFF_W];
      // Two's-complement sum at NOTE_W+2 bits; the MSB is the sign.
      assign sum      = {2'b00, rd_pitch} + {{(SUM_W-OFF_W){off[OFF_W-1]}}, off} + trans_ext;
      assign in_range = !sum[SUM_W-1] && (sum <= SUM_W'(NOTE_MAX));
      assign hit[gi]  = in_range && !is_rest;
      assign note_upd[gi*NOTE_W +: NOTE_W] = hit[gi] ? sum[NOTE_W-1:0] : voice_note[gi*NOTE_W +: NOTE_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_phase <= 1'b0;
      tick_cnt    <= '0;
      unit_cnt    <= '0;
      len_cur     <= '0;
      voice_note  <= '0;
      gate        <= '0;
      env_reset   <= '0;
      step_idx    <= '0;
      playing     <= 1'b0;
      loop_wrap   <= 1'b0;
    end else begin
      loop_wrap <= 1'b0;
      if (stop) begin
        state       <= IDLE;
        fetch_phase <= 1'b0;
        tick_cnt    <= '0;
        unit_cnt    <= '0;
        gate        <= '0;
        env_reset   <= '0;
        step_idx    <= '0;
        playing     <= 1'b0;
      end else if (start) begin
        state       <= FETCH;
        fetch_phase <= 1'b0;
        tick_cnt    <= '0;
        unit_cnt    <= '0;
        env_reset   <= '0;
        step_idx    <= '0;
        playing     <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          FETCH: begin
            if (!fetch_phase) begin
              fetch_phase <= 1'b1;
            end else begin
              fetch_phase <= 1'b0;
              if (rd_len == '0) begin
                if (step_idx != '0) begin
                  step_idx  <= '0;
                  loop_wrap <= 1'b1;
                end else begin
                  state     <= IDLE;
                  playing   <= 1'b0;
                  gate      <= '0;
                  env_reset <= '0;
                end
              end else begin
                state      <= PLAY;
                len_cur    <= rd_len;
                tick_cnt   <= '0;
                unit_cnt   <= '0;
                voice_note <= note_upd;
                gate       <= hit;
                env_reset  <= hit;
              end
            end
          end
          PLAY: begin
            if (sample_tick) begin
              env_reset <= '0;
              if (unit_end) begin
                tick_cnt <= '0;
                if (step_end) begin
                  unit_cnt    <= '0;
                  state       <= FETCH;
                  fetch_phase <= 1'b0;
                  if ({1'b0, step_idx} == loop_last) begin
                    step_idx  <= '0;
                    loop_wrap <= 1'b1;
                  end else begin
                    step_idx <= step_idx + 1'b1;
                  end
                end else begin
                  unit_cnt <= unit_cnt + 1'b1;
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected output changes (with tick/clk spacing) are queued,
// a negedge monitor pops and compares whenever the DUT output tuple changes.
module tb_note_sequencer;

  localparam int NV = 2, DEPTH = 64, AW = 6, NW = 6, LW = 4, TW = 16, OW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0;
  logic start = 1'b0, stop = 1'b0;
  logic [TW-1:0] tempo_div = 16'd4;
  logic [AW:0] loop_len = 7'd3;
  logic [NV*OW-1:0] voice_offset = {6'd4, 6'd0};
`ifdef SEQ_TRANSPOSE_EN
  logic [OW-1:0] transpose = '0;
`endif
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [NW-1:0] wr_pitch = '0;
  logic [LW-1:0] wr_len = '0;
  logic [NV*NW-1:0] voice_note;
  logic [NV-1:0] gate, env_reset;
  logic [AW-1:0] step_idx;
  logic playing, loop_wrap;

  note_sequencer dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .start(start), .stop(stop),
    .tempo_div(tempo_div), .loop_len(loop_len), .voice_offset(voice_offset),
`ifdef SEQ_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch), .wr_len(wr_len),
    .voice_note(voice_note), .gate(gate), .env_reset(env_reset),
    .step_idx(step_idx), .playing(playing), .loop_wrap(loop_wrap)
  );

  always #5 clk = ~clk;

  // Free-running sample tick: one clk high every 8 clks.
  initial begin
    forever begin
      repeat (7) @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
    end
  end

  typedef struct packed {
    logic [11:0] notes;
    logic [1:0]  gate;
    logic [1:0]  env;
    logic [5:0]  idx;
    logic        playing;
    logic        wrap;
  } obs_t;

  typedef struct {
    obs_t o;
    int   ticks;
    int   clks;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  obs_t prev;
  int mon_ticks = 0;
  int mon_clks = 0;

  function automatic obs_t mk(int n0, int n1, logic [1:0] g, logic [1:0] e, int idx, logic p, logic w);
    obs_t o;
    o.notes = {6'(n1), 6'(n0)};
    o.gate = g;
    o.env = e;
    o.idx = 6'(idx);
    o.playing = p;
    o.wrap = w;
    return o;
  endfunction

  task automatic push(input obs_t o, input int t, input int c);
    exp_t e;
    e.o = o;
    e.ticks = t;
    e.clks = c;
    exp_q.push_back(e);
  endtask

  // Monitor: spacing counters are compared before the current tick is counted.
  always @(negedge clk) begin
    obs_t cur;
    exp_t e;
    cur = {voice_note, gate, env_reset, step_idx, playing, loop_wrap};
    if (rst) begin
      prev = cur;
      mon_ticks = 0;
      mon_clks = 0;
    end else begin
      mon_clks++;
      if (cur !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_change got=%h", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.o || (e.ticks >= 0 && e.ticks != mon_ticks) || (e.clks >= 0 && e.clks != mon_clks)) begin
            fails++;
            $display("[TB] FAIL output_change got=%h ticks=%0d clks=%0d expected=%h ticks=%0d clks=%0d",
                     cur, mon_ticks, mon_clks, e.o, e.ticks, e.clks);
          end else begin
            $display("[TB] change ok obs=%h ticks=%0d clks=%0d", cur, mon_ticks, mon_clks);
          end
        end
        prev = cur;
        mon_ticks = 0;
        mon_clks = 0;
      end
      if (sample_tick) mon_ticks++;
    end
  end

  task automatic wr(input int a, input int p, input int l);
    @(posedge clk);
    #1 wr_en = 1'b1; wr_addr = 6'(a); wr_pitch = 6'(p); wr_len = 4'(l);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic pulse(input logic do_start, input logic do_stop);
    @(posedge clk);
    #1 start = do_start; stop = do_stop;
    @(posedge clk);
    #1 start = 1'b0; stop = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s drain_timeout remaining=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end else begin
      $display("[TB] %s drained", name);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t cur;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    cur = {voice_note, gate, env_reset, step_idx, playing, loop_wrap};
    if (cur !== '0) begin
      fails++;
      $display("[TB] FAIL reset_state got=%h required=0", cur);
    end else $display("[TB] reset_state ok");
    @(posedge clk);
    #1 rst = 1'b0;

    // End marker at step 0: FETCH for 2 clks then back to IDLE.
    wr(0, 5, 0);
    push(mk(0, 0, 2'b00, 2'b00, 0, 1, 0), -1, -1);
    push(mk(0, 0, 2'b00, 2'b00, 0, 0, 0), -1, 2);
    pulse(1, 0);
    drain("end_marker_step0");

    // Three-step loop with offsets {0,+4}.
    wr(0, 12, 1); wr(1, 16, 2); wr(2, 19, 1);
    push(mk(0, 0, 2'b00, 2'b00, 0, 1, 0), -1, -1);
    push(mk(12, 16, 2'b11, 2'b11, 0, 1, 0), -1, 2);
    push(mk(12, 16, 2'b11, 2'b00, 0, 1, 0), 1, -1);
    push(mk(12, 16, 2'b11, 2'b00, 1, 1, 0), 3, -1);
    push(mk(16, 20, 2'b11, 2'b11, 1, 1, 0), 0, 2);
    push(mk(16, 20, 2'b11, 2'b00, 1, 1, 0), 1, -1);
    push(mk(16, 20, 2'b11, 2'b00, 2, 1, 0), 7, -1);
    push(mk(19, 23, 2'b11, 2'b11, 2, 1, 0), 0, 2);
    push(mk(19, 23, 2'b11, 2'b00, 2, 1, 0), 1, -1);
    push(mk(19, 23, 2'b11, 2'b00, 0, 1, 1), 3, -1);
    push(mk(19, 23, 2'b11, 2'b00, 0, 1, 0), 0, 1);
    push(mk(12, 16, 2'b11, 2'b11, 0, 1, 0), 0, 1);
    push(mk(12, 16, 2'b11, 2'b00, 0, 1, 0), 1, -1);
    pulse(1, 0);
    drain("three_step_loop");
    push(mk(12, 16, 2'b00, 2'b00, 0, 0, 0), -1, -1);
    pulse(0, 1);
    drain("stop_mid_note");

    // Rest step then end marker wrapping back to step 0.
    wr(1, 63, 2); wr(2, 19, 0);
    push(mk(12, 16, 2'b00, 2'b00, 0, 1, 0), -1, -1);
    push(mk(12, 16, 2'b11, 2'b11, 0, 1, 0), -1, 2);
    push(mk(12, 16, 2'b11, 2'b00, 0, 1, 0), 1, -1);
    push(mk(12, 16, 2'b11, 2'b00, 1, 1, 0), 3, -1);
    push(mk(12, 16, 2'b00, 2'b00, 1, 1, 0), 0, 2);
    push(mk(12, 16, 2'b00, 2'b00, 2, 1, 0), 8, -1);
    push(mk(12, 16, 2'b00, 2'b00, 0, 1, 1), 0, 2);
    push(mk(12, 16, 2'b00, 2'b00, 0, 1, 0), 0, 1);
    push(mk(12, 16, 2'b11, 2'b11, 0, 1, 0), 0, 1);
    push(mk(12, 16, 2'b11, 2'b00, 0, 1, 0), 1, -1);
    pulse(1, 0);
    drain("rest_and_wrap");
    push(mk(12, 16, 2'b00, 2'b00, 0, 0, 0), -1, -1);
    pulse(0, 1);
    drain("stop_after_rest");

    // Out-of-range voice 1 (38+4 > 40).
    wr(0, 38, 1);
    push(mk(12, 16, 2'b00, 2'b00, 0, 1, 0), -1, -1);
    push(mk(38, 16, 2'b01, 2'b01, 0, 1, 0), -1, 2);
    push(mk(38, 16, 2'b01, 2'b00, 0, 1, 0), 1, -1);
    pulse(1, 0);
    drain("voice1_out_of_range");
    push(mk(38, 16, 2'b00, 2'b00, 0, 0, 0), -1, -1);
    pulse(0, 1);
    drain("stop_range");

    // start and stop together: stop wins, no output change.
    pulse(1, 1);
    repeat (4) @(posedge clk);
    #2;
    tests++;
    if ({playing, gate} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL start_stop_same got=%b required=000", {playing, gate});
    end else $display("[TB] start_stop_same ok");

    // Asynchronous reset mid-PLAY.
    wr(0, 12, 1);
    push(mk(38, 16, 2'b00, 2'b00, 0, 1, 0), -1, -1);
    push(mk(12, 16, 2'b11, 2'b11, 0, 1, 0), -1, 2);
    push(mk(12, 16, 2'b11, 2'b00, 0, 1, 0), 1, -1);
    pulse(1, 0);
    drain("before_async_reset");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    cur = {voice_note, gate, env_reset, step_idx, playing, loop_wrap};
    if (cur !== '0) begin
      fails++;
      $display("[TB] FAIL async_reset got=%h required=0", cur);
    end else $display("[TB] async_reset ok");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

`ifdef SEQ_TRANSPOSE_EN
    transpose = 6'h34;  // -12
    push(mk(0, 0, 2'b00, 2'b00, 0, 1, 0), -1, -1);
    push(mk(0, 4, 2'b11, 2'b11, 0, 1, 0), -1, 2);
    push(mk(0, 4, 2'b11, 2'b00, 0, 1, 0), 1, -1);
    pulse(1, 0);
    drain("transpose_to_zero");
    push(mk(0, 4, 2'b00, 2'b00, 0, 0, 0), -1, -1);
    pulse(0, 1);
    drain("transpose_stop");
    voice_offset = {6'd4, 6'h3f};
    push(mk(0, 4, 2'b00, 2'b00, 0, 1, 0), -1, -1);
    push(mk(0, 4, 2'b10, 2'b10, 0, 1, 0), -1, 2);
    push(mk(0, 4, 2'b10, 2'b00, 0, 1, 0), 1, -1);
    pulse(1, 0);
    drain("transpose_below_zero");
    push(mk(0, 4, 2'b00, 2'b00, 0, 0, 0), -1, -1);
    pulse(0, 1);
    drain("transpose_stop2");
`endif

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
